// File: rtl/sblk_row_acc.sv
// Row accumulator: sums NUM_COL partial-sum buffers over several passes, then drains them on a valid/ready stream.
// Optional macro SBLK_ROW_ACC_SAT_EN: saturating accumulation plus a sticky sat_flag output.
module sblk_row_acc #(
  parameter int NUM_COL = 4,
  parameter int DATA_W  = 24,
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 6
) (
  input  logic                      clk_l,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         cfg_depth_m1,
  input  logic [7:0]                cfg_passes_m1,
  input  logic                      cfg_en,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic                      pbuf_vld,
  output logic                      pbuf_ack,
  output logic [ADDR_W-1:0]         pbuf_rd_addr,
  input  logic [NUM_COL*DATA_W-1:0] pbuf_rd_data,
  output logic [NUM_COL*ACC_W-1:0]  out_data,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic                      out_last
`ifdef SBLK_ROW_ACC_SAT_EN
  ,
  output logic                      sat_flag
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_ACK   = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        pass_q, pass_d;
  logic [ADDR_W-1:0] depth_m1_q;
  logic [7:0]        passes_m1_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] rd_addr;
  logic              addr_at_end;
  logic              first_pass;

  assign addr_at_end = (addr_q == depth_m1_q);
  assign first_pass  = (pass_q == 8'd0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          addr_d  = '0;
          pass_d  = '0;
        end
      end
      S_WAIT: begin
        if (pbuf_vld) begin
          state_d = S_READ;
          addr_d  = '0;
        end
      end
      S_READ: begin
        if (addr_at_end) begin
          state_d = S_FLUSH;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_FLUSH: state_d = S_ACK;
      S_ACK: begin
        if (pass_q == passes_m1_q) begin
          state_d = S_DRAIN;
          addr_d  = '0;
        end else begin
          pass_d  = pass_q + 1'b1;
          state_d = S_WAIT;
        end
      end
      S_DRAIN: begin
        if (out_rdy) begin
          if (addr_at_end) begin
            state_d = S_DONE;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      pass_q      <= '0;
      depth_m1_q  <= '0;
      passes_m1_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      pass_q    <= pass_d;
      // Write-back trails the read address by the pbuf read latency.
      wr_en_q   <= (state_q == S_READ);
      wr_addr_q <= addr_q;
      if (cfg_en && (state_q == S_IDLE)) begin
        depth_m1_q  <= cfg_depth_m1;
        passes_m1_q <= cfg_passes_m1;
      end
    end
  end

  // While draining, prefetch the next entry so transfers run back-to-back and a stall re-reads the same entry.
  assign rd_addr = (state_q == S_READ) ? addr_q : addr_d;

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign pbuf_ack     = (state_q == S_ACK);
  assign out_vld      = (state_q == S_DRAIN);
  assign out_last     = out_vld && addr_at_end;
  assign pbuf_rd_addr = (state_q == S_READ) ? addr_q : '0;

`ifdef SBLK_ROW_ACC_SAT_EN
  logic [NUM_COL-1:0] col_clamp;
  logic               sat_q;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COL; gi++) begin : g_col
      logic [ACC_W-1:0]        mem [2**ADDR_W];
      logic [ACC_W-1:0]        rd_q;
      logic signed [DATA_W-1:0] din;
      logic signed [ACC_W-1:0]  data_ext;
      logic [ACC_W-1:0]        wr_data;

      assign din      = pbuf_rd_data[gi*DATA_W +: DATA_W];
      assign data_ext = ACC_W'(din);

`ifdef SBLK_ROW_ACC_SAT_EN
      logic [ACC_W:0] sum_w;
      logic           ovf;
      assign sum_w   = {rd_q[ACC_W-1], rd_q} + {data_ext[ACC_W-1], data_ext};
      assign ovf     = (sum_w[ACC_W] != sum_w[ACC_W-1]);
      assign wr_data = first_pass ? data_ext :
                       !ovf       ? sum_w[ACC_W-1:0] :
                       sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      assign col_clamp[gi] = wr_en_q && !first_pass && ovf;
`else
      assign wr_data = first_pass ? data_ext : rd_q + data_ext;
`endif

      always_ff @(posedge clk_l) begin
        if (wr_en_q) begin
          mem[wr_addr_q] <= wr_data;
        end
        rd_q <= mem[rd_addr];
      end

      assign out_data[gi*ACC_W +: ACC_W] = out_vld ? rd_q : '0;
    end
  endgenerate

`ifdef SBLK_ROW_ACC_SAT_EN
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start) begin
      sat_q <= 1'b0;
    end else if (|col_clamp) begin
      sat_q <= 1'b1;
    end
  end
  assign sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_sblk_row_acc.sv
// Directed bench for sblk_row_acc with a queue scoreboard; a second narrow instance exercises accumulator overflow.
module tb_sblk_row_acc;
  localparam int NC  = 4;
  localparam int DW  = 24;
  localparam int AW  = 32;
  localparam int ADW = 6;

  logic clk_l = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_l = ~clk_l;

  logic [ADW-1:0]   cfg_depth_m1;
  logic [7:0]       cfg_passes_m1;
  logic             cfg_en, start, busy, done, pbuf_vld, pbuf_ack;
  logic [ADW-1:0]   pbuf_rd_addr;
  logic [NC*DW-1:0] pbuf_rd_data;
  logic [NC*AW-1:0] out_data;
  logic             out_vld, out_rdy, out_last;

  logic             o_start, o_busy, o_done, o_pbuf_ack, o_out_vld, o_out_last;
  logic [1:0]       o_rd_addr;
  logic [23:0]      o_out_data;
`ifdef SBLK_ROW_ACC_SAT_EN
  logic             sat_flag, o_sat_flag;
`endif

  sblk_row_acc #(.NUM_COL(NC), .DATA_W(DW), .ACC_W(AW), .ADDR_W(ADW)) u_dut (
    .clk_l(clk_l), .rst_n(rst_n),
    .cfg_depth_m1(cfg_depth_m1), .cfg_passes_m1(cfg_passes_m1), .cfg_en(cfg_en),
    .start(start), .busy(busy), .done(done),
    .pbuf_vld(pbuf_vld), .pbuf_ack(pbuf_ack), .pbuf_rd_addr(pbuf_rd_addr), .pbuf_rd_data(pbuf_rd_data),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last)
`ifdef SBLK_ROW_ACC_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  sblk_row_acc #(.NUM_COL(1), .DATA_W(24), .ACC_W(24), .ADDR_W(2)) u_ovf (
    .clk_l(clk_l), .rst_n(rst_n),
    .cfg_depth_m1(2'd0), .cfg_passes_m1(8'd1), .cfg_en(1'b1),
    .start(o_start), .busy(o_busy), .done(o_done),
    .pbuf_vld(1'b1), .pbuf_ack(o_pbuf_ack), .pbuf_rd_addr(o_rd_addr), .pbuf_rd_data(24'h7FFFFF),
    .out_data(o_out_data), .out_vld(o_out_vld), .out_rdy(1'b1), .out_last(o_out_last)
`ifdef SBLK_ROW_ACC_SAT_EN
    , .sat_flag(o_sat_flag)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Column buffer model: one-cycle registered read.
  int mode = 0;
  function automatic logic [DW-1:0] pdata(input int m, input int c, input int a);
    logic [DW-1:0] v;
    case (m)
      0:       v = DW'(10 * c + a);
      1:       v = DW'(-5);
      2:       v = 24'h7FFFFF;
      default: v = DW'(500 + 7 * c + a);
    endcase
    return v;
  endfunction

  always @(posedge clk_l) begin
    for (int c = 0; c < NC; c++) pbuf_rd_data[c*DW +: DW] <= pdata(mode, c, int'(pbuf_rd_addr));
  end

  typedef struct packed {
    logic [NC*AW-1:0] data;
    logic             last;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input int m, input int d, input int p);
    for (int a = 0; a <= d; a++) begin
      exp_t e;
      for (int c = 0; c < NC; c++) begin
        longint s;
        s = longint'(signed'(pdata(m, c, a))) * (p + 1);
`ifdef SBLK_ROW_ACC_SAT_EN
        if (s > 64'sh7FFFFFFF) s = 64'sh7FFFFFFF;
        else if (s < -64'sh80000000) s = -64'sh80000000;
`endif
        e.data[c*AW +: AW] = s[AW-1:0];
      end
      e.last = (a == d);
      sb.push_back(e);
    end
  endtask

  // Output monitor: scoreboard pops, stall stability, done timing.
  int xfers = 0, acks = 0, dones = 0, exp_acks = 0, ack_base = 0;
  logic stall_q = 1'b0, exp_done = 1'b0, stall_last;
  logic [NC*AW-1:0] stall_data;
  always @(negedge clk_l) begin
    if (exp_done) begin
      chk("done_after_last", done, 1);
      exp_done = 1'b0;
    end
    if (pbuf_ack) acks++;
    if (done) dones++;
    if (stall_q) begin
      chk("stall_vld", out_vld, 1);
      chk("stall_data", out_data, stall_data);
      chk("stall_last", out_last, stall_last);
    end
    if (out_vld && out_rdy) begin
      chk("sb_nonempty", sb.size() > 0, 1);
      chk("acks_before_out", acks - ack_base, exp_acks);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_last", out_last, e.last);
        $display("xfer %0d data=%0h last=%0b", xfers, out_data, out_last);
      end
      xfers++;
      if (out_last) exp_done = 1'b1;
    end
    stall_q    = out_vld && !out_rdy;
    stall_data = out_data;
    stall_last = out_last;
  end

  task automatic do_cfg(input int d, input int p);
    @(posedge clk_l); #1;
    cfg_depth_m1 = ADW'(d); cfg_passes_m1 = 8'(p); cfg_en = 1'b1;
    @(posedge clk_l); #1;
    cfg_en = 1'b0;
  endtask

  task automatic start_job(input int m, input int d, input int p);
    mode = m;
    do_cfg(d, p);
    push_exp(m, d, p);
    ack_base = acks;
    exp_acks = p + 1;
    start = 1'b1;
    @(posedge clk_l); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    // Reconfigure and re-start while busy; both must be ignored.
    cfg_depth_m1 = ~cfg_depth_m1; cfg_passes_m1 = ~cfg_passes_m1; cfg_en = 1'b1; start = 1'b1;
    @(posedge clk_l); #1;
    cfg_en = 1'b0; start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit toggle);
    int base = dones;
    int k = 0;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    while (dones == base && k < bound) begin
      out_rdy = toggle ? pat[k % 4] : 1'b1;
      @(posedge clk_l); #1;
      k++;
    end
    out_rdy = 1'b1;
    chk("job_completes", dones - base, 1);
    chk("idle_after_done", busy, 0);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int xb;
    cfg_depth_m1 = '0; cfg_passes_m1 = '0; cfg_en = 1'b0; start = 1'b0;
    pbuf_vld = 1'b0; out_rdy = 1'b1; o_start = 1'b0;
    repeat (3) @(posedge clk_l);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack", pbuf_ack, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_rd_addr", pbuf_rd_addr, 0);
    chk("rst_out_data", out_data, 0);
`ifdef SBLK_ROW_ACC_SAT_EN
    chk("rst_sat_flag", sat_flag, 0);
`endif
    #2 rst_n = 1'b1;
    pbuf_vld = 1'b1;

    // 1: single pass, ramp data
    xb = xfers;
    start_job(0, 3, 0);
    wait_done(200, 1'b0);
    chk("t1_xfers", xfers - xb, 4);

    // 2: three passes of -5
    start_job(1, 1, 2);
    wait_done(300, 1'b0);
    chk("t2_acks", acks - ack_base, 3);

    // 3: producer not ready for 20 cycles
    pbuf_vld = 1'b0;
    start_job(0, 3, 0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_l); #1;
      chk("t3_wait_addr", pbuf_rd_addr, 0);
      chk("t3_wait_busy", busy, 1);
      chk("t3_wait_ack", pbuf_ack, 0);
    end
    pbuf_vld = 1'b1;
    @(posedge clk_l); #1;
    chk("t3_read_addr0", pbuf_rd_addr, 0);
    @(posedge clk_l); #1;
    chk("t3_read_addr1", pbuf_rd_addr, 1);
    wait_done(200, 1'b0);

    // 4: drain with back-pressure
    xb = xfers;
    start_job(0, 3, 1);
    wait_done(300, 1'b1);
    chk("t4_xfers", xfers - xb, 4);

    // 5: large positive sums, then overflow on the narrow instance
    start_job(2, 0, 255);
    wait_done(3000, 1'b0);
`ifdef SBLK_ROW_ACC_SAT_EN
    chk("t5_no_sat", sat_flag, 0);
`endif
    @(posedge clk_l); #1;
    o_start = 1'b1;
    @(posedge clk_l); #1;
    o_start = 1'b0;
    for (int k = 0; k < 50 && !o_out_vld; k++) @(negedge clk_l);
    chk("t5_ovf_vld", o_out_vld, 1);
`ifdef SBLK_ROW_ACC_SAT_EN
    chk("t5_ovf_data", o_out_data, 24'h7FFFFF);
    chk("t5_ovf_sat", o_sat_flag, 1);
`else
    chk("t5_ovf_data", o_out_data, 24'hFFFFFE);
`endif
    chk("t5_ovf_last", o_out_last, 1);
    repeat (4) @(posedge clk_l);
    #1;
    chk("t5_ovf_idle", o_busy, 0);

    // 6: reset mid-READ, then a clean job
    mode = 3;
    do_cfg(3, 0);
    start = 1'b1;
    @(posedge clk_l); #1;
    start = 1'b0;
    @(posedge clk_l); #1;
    @(posedge clk_l); #1;
    chk("t6_pre_rst_addr", pbuf_rd_addr, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_ack", pbuf_ack, 0);
    chk("t6_rst_out_vld", out_vld, 0);
    chk("t6_rst_out_last", out_last, 0);
    chk("t6_rst_rd_addr", pbuf_rd_addr, 0);
    chk("t6_rst_out_data", out_data, 0);
    @(posedge clk_l); #3;
    rst_n = 1'b1;
    xb = xfers;
    start_job(0, 3, 1);
    wait_done(300, 1'b0);
    chk("t6_xfers", xfers - xb, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
